pixel_mem_arbiter: RTL and testbench
====================================

PIXEL_MEM_ARBITER -- requirements
Module: pixel_mem_arbiter

Interface
REQ-001 Parameters SHALL be: SIZE, default 1000000, memory depth in words; WIDTH, default 16, pixel width in bits; AW = $clog2(SIZE), derived address width; NREQ fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  4  per-requester request valid.
REQ-005 req_ready  output  4  per-requester grant; at most one bit high per cycle.
REQ-006 req_wr  input  4  per-requester write (1) / read (0) select.
REQ-007 req_addr  input  4*AW  flattened addresses; requester i at bits [i*AW +: AW].
REQ-008 req_data  input  4*WIDTH  flattened write data; requester i at bits [i*WIDTH +: WIDTH].
REQ-009 rsp_valid  output  4  one-cycle read-return pulse, one-hot.
REQ-010 rsp_err  output  1  qualifies rsp_valid; high when the read address was >= SIZE.
REQ-011 rsp_data  output  WIDTH  read data; valid only while any rsp_valid bit is high.
REQ-012 mem_enable  output  1  to memory port enable.
REQ-013 mem_wr_enable  output  1  to memory port write enable.
REQ-014 mem_addr  output  AW  to memory port address.
REQ-015 mem_pixel_in  output  WIDTH  to memory port write data.
REQ-016 mem_pixel_out  input  WIDTH  from memory port read data; 1-cycle registered read latency.

Function
REQ-017 Handshake: a request SHALL be accepted on a rising edge where req_valid[i] and req_ready[i] are both high; a requester holds valid, wr, addr and data stable until accepted.
REQ-018 req_ready SHALL be combinational from req_valid and the priority pointer, and SHALL never be high for a requester whose req_valid is low.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod 4; last_granted resets to 3 so requester 0 wins first; the pointer updates only on acceptance.
REQ-020 One acceptance per cycle; back-to-back acceptances every cycle SHALL be supported with no bubble.
REQ-021 mem_* outputs SHALL be registered: in the cycle after acceptance, mem_enable=1, mem_wr_enable=req_wr, mem_addr=req_addr, mem_pixel_in=req_data (0 for reads).
REQ-022 In cycles with no acceptance on the prior edge, mem_enable and mem_wr_enable SHALL be 0; mem_addr and mem_pixel_in hold.
REQ-023 Reads: rsp_valid[i] SHALL pulse exactly 2 cycles after acceptance, with rsp_data = mem_pixel_out passed through combinationally.
REQ-024 Writes SHALL produce no rsp_valid.
REQ-025 Out-of-range (req_addr >= SIZE): the request is accepted with mem_enable=0. A read still pulses rsp_valid at +2 with rsp_err=1 and rsp_data=0; a write is dropped silently.
REQ-026 Read-return tags SHALL be a 2-stage shift pipeline of (one-hot id, err), so up to 2 reads are in flight with no loss.
REQ-027 Two requesters raising valid in the same cycle: only the winner is granted; the loser stays pending and is granted next if it is next in round-robin order.

Reset
REQ-028 While rst is high: req_ready=0, rsp_valid=0, rsp_err=0, mem_enable=0, mem_wr_enable=0, mem_addr=0, mem_pixel_in=0, last_granted=3.
REQ-029 rst asserted mid-operation SHALL discard in-flight read tags; no rsp_valid is issued for reads accepted before reset.
REQ-030 After rst deasserts, the first acceptance is possible on the first rising edge.

Configuration
REQ-031 Macro PIXEL_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (requester 0 highest, 3 lowest) and the pointer logic is removed; when undefined, round-robin per REQ-019 applies.

Verification
REQ-032 Reset, then req_valid=4'b1111 held with all reads -> grants 0,1,2,3,0 on consecutive cycles; with PIXEL_ARB_FIXED_PRIO_EN -> grant 0 every cycle.
REQ-033 Requester 2 writes 16'hABCD to addr 5, then reads addr 5 -> mem_enable=1 and mem_wr_enable=1 one cycle after the write acceptance; rsp_valid=4'b0100 with rsp_data=16'hABCD 2 cycles after the read acceptance.
REQ-034 Requester 1 reads addr 1000000 -> mem_enable stays 0; rsp_valid=4'b0010 and rsp_err=1 at +2 cycles, rsp_data=0.
REQ-035 Back-to-back reads by requesters 0 then 3 -> rsp_valid=0001 then 1000 on consecutive cycles, with data matching memory contents.
REQ-036 Read accepted, rst pulsed the next cycle -> no rsp_valid afterward; all outputs 0 while rst is high.

Source files
------------

// File: rtl/pixel_mem_arbiter.sv
// Four-requester arbiter in front of a single-port pixel memory.
// Define PIXEL_ARB_FIXED_PRIO_EN for fixed priority; default is round-robin.
module pixel_mem_arbiter #(
  parameter int SIZE = 1000000,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [3:0]         req_wr,
  input  logic [4*AW-1:0]    req_addr,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         rsp_valid,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               mem_enable,
  output logic               mem_wr_enable,
  output logic [AW-1:0]      mem_addr,
  output logic [WIDTH-1:0]   mem_pixel_in,
  input  logic [WIDTH-1:0]   mem_pixel_out
);

  localparam logic [AW:0] SIZE_W = SIZE[AW:0];

  logic [3:0]       grant_raw;
  logic [3:0]       grant;
  logic [1:0]       win;
  logic             accept;
  logic [AW-1:0]    addr_a [4];
  logic [WIDTH-1:0] data_a [4];
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic             sel_wr;
  logic             in_range;
  logic [3:0]       tag1_id;
  logic             tag1_err;
  logic [3:0]       tag2_id;
  logic             tag2_err;

`ifdef PIXEL_ARB_FIXED_PRIO_EN
  // Lowest index wins outright.
  always_comb begin
    grant_raw = '0;
    priority case (1'b1)
      req_valid[0]: grant_raw = 4'b0001;
      req_valid[1]: grant_raw = 4'b0010;
      req_valid[2]: grant_raw = 4'b0100;
      req_valid[3]: grant_raw = 4'b1000;
      default:      grant_raw = 4'b0000;
    endcase
  end
`else
  logic [1:0] last_granted;
  logic [1:0] idx;
  logic       found;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    grant_raw = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_granted + 2'(k);
      if (!found && req_valid[idx]) begin
        grant_raw[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // Pointer moves only when a request is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_granted <= 2'd3;
    end else if (accept) begin
      last_granted <= win;
    end
  end
`endif

  // Grants are suppressed while reset is held.
  always_comb begin
    grant     = rst ? 4'b0000 : grant_raw;
    req_ready = grant;
    accept    = |grant;
  end

  // One-hot grant to winner index.
  always_comb begin
    win = '0;
    unique case (1'b1)
      grant[0]: win = 2'd0;
      grant[1]: win = 2'd1;
      grant[2]: win = 2'd2;
      grant[3]: win = 2'd3;
      default:  win = 2'd0;
    endcase
  end

  // Unpack the flattened request buses and pick the winner's fields.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = req_addr[i*AW +: AW];
      data_a[i] = req_data[i*WIDTH +: WIDTH];
    end
    sel_addr = addr_a[win];
    sel_data = data_a[win];
    sel_wr   = req_wr[win];
    in_range = {1'b0, sel_addr} < SIZE_W;
  end

  // Registered memory port; out-of-range requests never enable it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_enable    <= 1'b0;
      mem_wr_enable <= 1'b0;
      mem_addr      <= '0;
      mem_pixel_in  <= '0;
    end else begin
      mem_enable    <= accept & in_range;
      mem_wr_enable <= accept & in_range & sel_wr;
      if (accept) begin
        mem_addr     <= sel_addr;
        mem_pixel_in <= sel_wr ? sel_data : '0;
      end
    end
  end

  // Read tags ride a two-stage pipe to line up with memory latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1_id  <= '0;
      tag1_err <= 1'b0;
      tag2_id  <= '0;
      tag2_err <= 1'b0;
    end else begin
      tag1_id  <= (accept && !sel_wr) ? grant : 4'b0000;
      tag1_err <= accept & ~sel_wr & ~in_range;
      tag2_id  <= tag1_id;
      tag2_err <= tag1_err;
    end
  end

  // Response outputs; data is zeroed for errored or idle slots.
  always_comb begin
    rsp_valid = tag2_id;
    rsp_err   = tag2_err & (|tag2_id);
    rsp_data  = ((|tag2_id) && !tag2_err) ? mem_pixel_out : '0;
  end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Randomised + directed bench for pixel_mem_arbiter.
// Compares against a transaction-level model with a behavioural memory.
module tb_pixel_mem_arbiter;

  localparam int SIZE  = 1000000;
  localparam int WIDTH = 16;
  localparam int AW    = $clog2(SIZE);

  logic               clk;
  logic               rst;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [3:0]         req_wr;
  logic [4*AW-1:0]    req_addr;
  logic [4*WIDTH-1:0] req_data;
  logic [3:0]         rsp_valid;
  logic               rsp_err;
  logic [WIDTH-1:0]   rsp_data;
  logic               mem_enable;
  logic               mem_wr_enable;
  logic [AW-1:0]      mem_addr;
  logic [WIDTH-1:0]   mem_pixel_in;
  logic [WIDTH-1:0]   mem_pixel_out;

  pixel_mem_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .mem_enable(mem_enable), .mem_wr_enable(mem_wr_enable),
    .mem_addr(mem_addr), .mem_pixel_in(mem_pixel_in),
    .mem_pixel_out(mem_pixel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory with registered read.
  bit [WIDTH-1:0] env_mem [int];
  initial mem_pixel_out = '0;
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_wr_enable) env_mem[int'(mem_addr)] = mem_pixel_in;
      else mem_pixel_out <= env_mem[int'(mem_addr)];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Requester-side state: each holds a request until it is taken.
  logic          rq_v [4];
  logic          rq_w [4];
  logic [AW-1:0] rq_a [4];
  logic [15:0]   rq_d [4];

  bit auto_mode = 0;
  int refill_pct = 0;
  int wr_pct = 0;
  int oor_pct = 0;
  logic rst_next = 1'b1;

  // Reference model state.
  int ptr = 3;
  int cyc = 0;
  bit [WIDTH-1:0] ref_mem [int];
  logic [3:0]  rsp_id [int];
  logic        rsp_e  [int];
  logic [15:0] rsp_d  [int];
  logic        exp_men, exp_mwe;
  logic [AW-1:0] exp_maddr;
  logic [15:0] exp_mpix;
  bit   pend_wr = 0;
  int   pend_a;
  logic [15:0] pend_d;

  logic [3:0]  obs_ready, obs_rv;
  logic        obs_men, obs_mwe, obs_rerr;
  logic [15:0] obs_rdata;

  task automatic new_req(input int i);
    rq_v[i] = 1'b1;
    rq_w[i] = ($urandom_range(99) < wr_pct);
    if ($urandom_range(99) < oor_pct)
      rq_a[i] = AW'(SIZE + $urandom_range(48575));
    else
      rq_a[i] = AW'($urandom_range(15));
    rq_d[i] = 16'($urandom);
  endtask

  task automatic set_req(input int i, input logic w,
                         input int a, input logic [15:0] d);
    rq_v[i] = 1'b1;
    rq_w[i] = w;
    rq_a[i] = AW'(a);
    rq_d[i] = d;
  endtask

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    int j;
    g = '0;
`ifdef PIXEL_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) if (rq_v[i]) g = 4'(1 << i);
    j = 0;
`else
    for (int k = 4; k >= 1; k--) begin
      j = (ptr + k) % 4;
      if (rq_v[j]) g = 4'(1 << j);
    end
`endif
    return g;
  endfunction

  // One clock cycle: drive, check, then advance the model across the edge.
  task automatic step();
    logic [3:0] g;
    logic [3:0] erv;
    int w;
    int a;
    bit inr;
    @(negedge clk);
    rst = rst_next;
    if (auto_mode && !rst)
      for (int i = 0; i < 4; i++)
        if (!rq_v[i] && $urandom_range(99) < refill_pct / 2) new_req(i);
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = rq_v[i];
      req_wr[i] = rq_w[i];
      req_addr[i*AW +: AW] = rq_a[i];
      req_data[i*WIDTH +: WIDTH] = rq_d[i];
    end
    #1;
    obs_ready = req_ready;
    obs_men = mem_enable;
    obs_mwe = mem_wr_enable;
    obs_rv = rsp_valid;
    obs_rerr = rsp_err;
    obs_rdata = rsp_data;
    g = rst ? 4'b0000 : model_grant();
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rv", 32'(rsp_valid), 0);
      chk("rst_err", 32'(rsp_err), 0);
      chk("rst_men", 32'(mem_enable), 0);
      chk("rst_mwe", 32'(mem_wr_enable), 0);
      chk("rst_maddr", 32'(mem_addr), 0);
      chk("rst_mpix", 32'(mem_pixel_in), 0);
    end else begin
      erv = rsp_id.exists(cyc) ? rsp_id[cyc] : 4'b0000;
      chk("ready", 32'(req_ready), 32'(g));
      chk("men", 32'(mem_enable), 32'(exp_men));
      chk("mwe", 32'(mem_wr_enable), 32'(exp_mwe));
      chk("maddr", 32'(mem_addr), 32'(exp_maddr));
      chk("mpix", 32'(mem_pixel_in), 32'(exp_mpix));
      chk("rv", 32'(rsp_valid), 32'(erv));
      chk("rerr", 32'(rsp_err), erv != 0 ? 32'(rsp_e[cyc]) : 0);
      if (erv != 0) chk("rdata", 32'(rsp_data), 32'(rsp_d[cyc]));
    end
    if (rst) begin
      ptr = 3;
      exp_men = 0; exp_mwe = 0; exp_maddr = '0; exp_mpix = '0;
      pend_wr = 0;
      rsp_id.delete(); rsp_e.delete(); rsp_d.delete();
    end else begin
      if (pend_wr) ref_mem[pend_a] = pend_d;
      pend_wr = 0;
      if (g != 0) begin
        w = 0;
        for (int i = 0; i < 4; i++) if (g[i]) w = i;
        ptr = w;
        a = int'(rq_a[w]);
        inr = a < SIZE;
        exp_men = inr;
        exp_mwe = inr && rq_w[w];
        exp_maddr = rq_a[w];
        exp_mpix = rq_w[w] ? rq_d[w] : 16'h0;
        if (rq_w[w]) begin
          if (inr) begin pend_wr = 1; pend_a = a; pend_d = rq_d[w]; end
        end else begin
          rsp_id[cyc+2] = g;
          rsp_e[cyc+2] = !inr;
          rsp_d[cyc+2] = inr ? ref_mem[a] : 16'h0;
        end
        if ($urandom_range(99) < refill_pct) new_req(w);
        else rq_v[w] = 1'b0;
      end else begin
        exp_men = 0;
        exp_mwe = 0;
      end
    end
    cyc++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      rq_v[i] = 0; rq_w[i] = 0; rq_a[i] = '0; rq_d[i] = '0;
    end
  endtask

  logic [3:0] exp_g;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_data = '0;
    exp_men = 0; exp_mwe = 0; exp_maddr = '0; exp_mpix = '0;
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 0, i, 16'h0);

    // Reset with all requesters asserting valid.
    rst_next = 1; step(); step();
    rst_next = 0;

    // All four hold valid reads: grant order check.
    refill_pct = 100; wr_pct = 0; oor_pct = 0;
    for (int k = 0; k < 5; k++) begin
      step();
`ifdef PIXEL_ARB_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'(1 << (k % 4));
`endif
      chk("rr_seq", 32'(obs_ready), 32'(exp_g));
    end
    refill_pct = 0;
    clear_reqs();
    step(); step(); step();

    // Requester 2 writes then reads back address 5.
    set_req(2, 1, 5, 16'hABCD);
    step(); chk("wr_grant", 32'(obs_ready), 32'h4);
    step(); chk("wr_men", 32'(obs_men), 1); chk("wr_mwe", 32'(obs_mwe), 1);
    set_req(2, 0, 5, 16'h0);
    step(); chk("rd_grant", 32'(obs_ready), 32'h4);
    step();
    step(); chk("rd_rv", 32'(obs_rv), 32'h4);
    chk("rd_data", 32'(obs_rdata), 32'hABCD);

    // Requester 1 reads an out-of-range address.
    set_req(1, 0, SIZE, 16'h0);
    step(); chk("oor_grant", 32'(obs_ready), 32'h2);
    step(); chk("oor_men", 32'(obs_men), 0);
    step(); chk("oor_rv", 32'(obs_rv), 32'h2);
    chk("oor_err", 32'(obs_rerr), 1);
    chk("oor_data", 32'(obs_rdata), 0);

    // Back-to-back reads by requesters 0 and 3.
    set_req(3, 1, 7, 16'h1234);
    step(); step(); step();
    set_req(0, 0, 5, 16'h0);
    step();
    set_req(3, 0, 7, 16'h0);
    step();
    step(); chk("b2b_rv0", 32'(obs_rv), 32'h1);
    chk("b2b_d0", 32'(obs_rdata), 32'hABCD);
    step(); chk("b2b_rv3", 32'(obs_rv), 32'h8);
    chk("b2b_d3", 32'(obs_rdata), 32'h1234);

    // Read accepted, then reset on the next cycle.
    set_req(0, 0, 5, 16'h0);
    step(); chk("rstmid_grant", 32'(obs_ready), 32'h1);
    rst_next = 1; step();
    rst_next = 0;
    for (int k = 0; k < 3; k++) begin
      step(); chk("rstmid_rv", 32'(obs_rv), 0);
    end

    // Randomised traffic with occasional reset pulses.
    auto_mode = 1; refill_pct = 60; wr_pct = 40; oor_pct = 10;
    for (int n = 0; n < 3000; n++) begin
      rst_next = ($urandom_range(299) == 0);
      step();
    end
    rst_next = 0;
    auto_mode = 0; refill_pct = 0;
    clear_reqs();
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
